// File: rtl/c64_loader_pkg.sv
// Shared types and constants for the C64 PRG loader.
// Zero-page pointer locations patched after a load.
package c64_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_RAM_WR,
        S_PTR_WR,
        S_DONE
    } state_t;

    localparam logic [7:0]  ZP_VARTAB       = 8'h2D;
    localparam logic [7:0]  ZP_ARYTAB       = 8'h2F;
    localparam logic [7:0]  ZP_STREND       = 8'h31;
    localparam logic [7:0]  ZP_EAL          = 8'hAE;
    localparam logic [15:0] BASIC_START_DEF = 16'h0801;

    // idx 0/1 -> $AE/$AF, 2..7 -> $2D..$32
    function automatic logic [15:0] zp_addr(input logic [2:0] idx);
        logic [7:0] base;
        base = ZP_EAL;
        case (idx[2:1])
            2'd0: base = ZP_EAL;
            2'd1: base = ZP_VARTAB;
            2'd2: base = ZP_ARYTAB;
            2'd3: base = ZP_STREND;
            default: base = ZP_EAL;
        endcase
        return {8'h00, base + {7'd0, idx[0]}};
    endfunction

endpackage

// File: rtl/prg_ptr_writer.sv
// Writes prg_end into the KERNAL/BASIC end-of-program pointers
// through the shared RAM req/ack port.
module prg_ptr_writer
    import c64_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] prg_end,
    input  logic        is_basic,
    input  logic        ram_ack,
    output logic        ram_req,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        done
);

    logic       busy;
    logic       basic_q;
    logic [2:0] idx;
    logic [2:0] last_idx;

    assign last_idx = basic_q ? 3'd7 : 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            basic_q  <= 1'b0;
            idx      <= 3'd0;
            ram_req  <= 1'b0;
            ram_addr <= 16'h0000;
            ram_dout <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy    <= 1'b1;
                basic_q <= is_basic;
                idx     <= 3'd0;
                ram_req <= 1'b0;
            end else if (busy) begin
                if (ram_req) begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        if (idx == last_idx) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end else begin
                    // one idle cycle between writes keeps each req distinct
                    ram_req  <= 1'b1;
                    ram_addr <= zp_addr(idx);
                    ram_dout <= idx[0] ? prg_end[15:8] : prg_end[7:0];
                end
            end
        end
    end

endmodule

// File: rtl/prg_ram_loader.sv
// Streams a PRG image from the SD loader into C64 RAM, stripping
// the load-address header and patching the end-of-program pointers.
module prg_ram_loader
    import c64_loader_pkg::*;
#(
    parameter bit          PTR_UPDATE  = 1'b1,
    parameter logic [15:0] BASIC_START = BASIC_START_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        load_prg,
    input  logic [22:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_req,
    input  logic        ram_ack,
    output logic [15:0] prg_start,
    output logic [15:0] prg_end,
    output logic        prg_done,
    output logic        prg_error
);

    state_t      state;
    logic        dl_prev;
    logic [16:0] ptr;
    logic [22:0] exp_addr;
    logic [15:0] m_addr;
    logic [7:0]  m_dout;
    logic        m_req;
    logic        pw_start;
    logic        pw_req;
    logic [15:0] pw_addr;
    logic [7:0]  pw_dout;
    logic        pw_done;
    logic        dl;
    logic        dl_rise;
    logic        strobe;

    assign dl      = ioctl_download & load_prg;
    assign dl_rise = dl & ~dl_prev;
    assign strobe  = ioctl_wr & ioctl_download & load_prg;

    assign ram_req  = m_req | pw_req;
    assign ram_addr = (state == S_PTR_WR) ? pw_addr : m_addr;
    assign ram_dout = (state == S_PTR_WR) ? pw_dout : m_dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            dl_prev    <= 1'b0;
            ptr        <= 17'd0;
            exp_addr   <= 23'd0;
            m_addr     <= 16'h0000;
            m_dout     <= 8'h00;
            m_req      <= 1'b0;
            pw_start   <= 1'b0;
            ioctl_wait <= 1'b0;
            prg_start  <= 16'h0000;
            prg_end    <= 16'h0000;
            prg_done   <= 1'b0;
            prg_error  <= 1'b0;
        end else begin
            dl_prev  <= dl;
            pw_start <= 1'b0;
            prg_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (dl_rise) begin
                        prg_error <= 1'b0;
                        state     <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (!ioctl_download) begin
                        prg_error  <= 1'b1;
                        ioctl_wait <= 1'b1;
                        state      <= S_DONE;
                    end else if (strobe) begin
                        prg_start[7:0] <= ioctl_data;
                        state          <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (!ioctl_download) begin
                        prg_error  <= 1'b1;
                        ioctl_wait <= 1'b1;
                        state      <= S_DONE;
                    end else if (strobe) begin
                        prg_start[15:8] <= ioctl_data;
                        ptr      <= {1'b0, ioctl_data, prg_start[7:0]};
                        exp_addr <= 23'd2;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!ioctl_download) begin
                        // ptr[16] marks a payload that ran past $FFFF
                        prg_end    <= ptr[16] ? 16'hFFFF : ptr[15:0];
                        ioctl_wait <= 1'b1;
                        if (PTR_UPDATE) begin
                            pw_start <= 1'b1;
                            state    <= S_PTR_WR;
                        end else begin
                            state <= S_DONE;
                        end
                    end else if (strobe) begin
                        exp_addr <= exp_addr + 23'd1;
                        if (ioctl_addr != exp_addr)
                            prg_error <= 1'b1;
                        if (ptr[16]) begin
                            prg_error <= 1'b1;
                        end else begin
                            m_addr     <= ptr[15:0];
                            m_dout     <= ioctl_data;
                            m_req      <= 1'b1;
                            ioctl_wait <= 1'b1;
                            state      <= S_RAM_WR;
                        end
                    end
                end
                S_RAM_WR: begin
                    if (ram_ack) begin
                        m_req      <= 1'b0;
                        ioctl_wait <= 1'b0;
                        ptr        <= ptr + 17'd1;
                        state      <= S_DATA;
                    end
                end
                S_PTR_WR: begin
                    if (pw_done)
                        state <= S_DONE;
                end
                S_DONE: begin
                    prg_done   <= 1'b1;
                    ioctl_wait <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    prg_ptr_writer u_ptr_writer (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (pw_start),
        .prg_end  (prg_end),
        .is_basic (prg_start == BASIC_START),
        .ram_ack  (ram_ack),
        .ram_req  (pw_req),
        .ram_addr (pw_addr),
        .ram_dout (pw_dout),
        .done     (pw_done)
    );

endmodule

// File: tb/tb_prg_ram_loader.sv
// Bench for prg_ram_loader: table vectors, random images against a
// reference model, plus stalled-ack and reset-during-patch sequences.
module tb_prg_ram_loader;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [15:0] start;
        int          npay;
        int          lat;
        int          nhdr;
        logic [15:0] e_end;
        logic        e_err;
        int          e_nw;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        load_prg = 1'b0;
    logic [22:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic        ioctl_wait;
    logic [15:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_req;
    logic        ram_ack = 1'b0;
    logic [15:0] prg_start;
    logic [15:0] prg_end;
    logic        prg_done;
    logic        prg_error;

    int n_chk = 0;
    int n_fail = 0;

    int          lat = 1;
    logic        hold_ack = 1'b0;
    int          wcnt = 0;
    logic [15:0] cap_a;
    logic [7:0]  cap_d;
    logic [23:0] wq[$];
    int          unstable = 0;
    int          done_cnt = 0;

    int wq_base = 0;
    int done_base = 0;
    int unst_base = 0;

    logic [23:0] exp_w[$];
    logic        exp_err;
    logic [15:0] exp_end;
    logic        has_hdr;
    int          last_nw;

    always #5 clk = ~clk;

    prg_ram_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .load_prg       (load_prg),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wr       (ioctl_wr),
        .ioctl_wait     (ioctl_wait),
        .ram_addr       (ram_addr),
        .ram_dout       (ram_dout),
        .ram_req        (ram_req),
        .ram_ack        (ram_ack),
        .prg_start      (prg_start),
        .prg_end        (prg_end),
        .prg_done       (prg_done),
        .prg_error      (prg_error)
    );

    // RAM arbiter: acks after lat waiting cycles, logs every accepted write
    always @(negedge clk) begin
        if (!reset_n || ram_ack) begin
            ram_ack = 1'b0;
            wcnt = 0;
        end else if (ram_req) begin
            if (wcnt == 0) begin
                cap_a = ram_addr;
                cap_d = ram_dout;
            end else if (ram_addr !== cap_a || ram_dout !== cap_d) begin
                unstable++;
            end
            wcnt++;
            if (wcnt > lat && !hold_ack) begin
                ram_ack = 1'b1;
                wq.push_back({ram_addr, ram_dout});
            end
        end
    end

    always @(negedge clk) begin
        if (prg_done === 1'b1)
            done_cnt++;
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model(input bq_t b, input int badk);
        int n;
        int s;
        int e;
        n = b.size();
        exp_w.delete();
        exp_err = 1'b0;
        exp_end = 16'h0000;
        has_hdr = (n >= 2);
        if (!has_hdr) begin
            exp_err = 1'b1;
            return;
        end
        s = int'({b[1], b[0]});
        if (badk >= 2 && badk < n)
            exp_err = 1'b1;
        for (int k = 0; k < n - 2; k++) begin
            if (s + k > 65535)
                exp_err = 1'b1;
            else
                exp_w.push_back({16'(s + k), b[k + 2]});
        end
        e = s + n - 2;
        if (e > 65535)
            e = 65535;
        exp_end = 16'(e);
        exp_w.push_back({16'h00AE, exp_end[7:0]});
        exp_w.push_back({16'h00AF, exp_end[15:8]});
        if (s == 16'h0801) begin
            for (int j = 0; j < 3; j++) begin
                exp_w.push_back({16'(16'h002D + 2 * j), exp_end[7:0]});
                exp_w.push_back({16'(16'h002E + 2 * j), exp_end[15:8]});
            end
        end
    endtask

    task automatic dl_begin();
        @(negedge clk);
        wq_base = wq.size();
        done_base = done_cnt;
        unst_base = unstable;
        load_prg = 1'b1;
        ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (ioctl_wait && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (ioctl_wait)
            check("wait_timeout", 64'(ioctl_wait), 64'd0);
    endtask

    task automatic send_byte(input logic [22:0] a, input logic [7:0] d);
        wait_ready();
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic dl_end();
        wait_ready();
        ioctl_download = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == done_base && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        load_prg = 1'b0;
    endtask

    task automatic run_case(input bq_t b, input int badk, input int l);
        int mism;
        int nw;
        lat = l;
        model(b, badk);
        dl_begin();
        for (int i = 0; i < b.size(); i++)
            send_byte((i == badk) ? 23'(i + 5) : 23'(i), b[i]);
        dl_end();
        wait_done();
        nw = wq.size() - wq_base;
        last_nw = nw;
        check("nwrites", 64'(nw), 64'(exp_w.size()));
        mism = 0;
        for (int i = 0; i < nw && i < exp_w.size(); i++)
            if (wq[wq_base + i] !== exp_w[i])
                mism++;
        check("write_contents", 64'(mism), 64'd0);
        check("prg_error", 64'(prg_error), 64'(exp_err));
        if (has_hdr) begin
            check("prg_end", 64'(prg_end), 64'(exp_end));
            check("prg_start", 64'(prg_start), 64'({b[1], b[0]}));
        end
        check("done_pulses", 64'(done_cnt - done_base), 64'd1);
        check("ram_stable", 64'(unstable - unst_base), 64'd0);
    endtask

    function automatic bq_t mk_img(input logic [15:0] s, input int nhdr,
                                   input int npay, input bit rnd);
        bq_t b;
        if (nhdr >= 1) b.push_back(s[7:0]);
        if (nhdr >= 2) b.push_back(s[15:8]);
        for (int k = 0; k < npay; k++)
            b.push_back(rnd ? 8'($urandom) : 8'(8'hAA + 8'h11 * k));
        return b;
    endfunction

    vec_t vt[7];

    initial begin
        bq_t b;
        logic [15:0] s;
        int np;
        int bad;
        int t;
        int nb;
        logic ok_wait;

        vt[0] = '{16'h0801, 3, 3, 2, 16'h0804, 1'b0, 11};
        vt[1] = '{16'hC000, 4, 1, 2, 16'hC004, 1'b0, 6};
        vt[2] = '{16'hFFFE, 4, 2, 2, 16'hFFFF, 1'b1, 4};
        vt[3] = '{16'h0000, 0, 1, 1, 16'h0000, 1'b1, 0};
        vt[4] = '{16'h1000, 0, 0, 2, 16'h1000, 1'b0, 2};
        vt[5] = '{16'hFFFF, 1, 2, 2, 16'hFFFF, 1'b0, 3};
        vt[6] = '{16'h0801, 0, 0, 2, 16'h0801, 1'b0, 8};

        repeat (3) @(negedge clk);
        check("reset_state",
              {ioctl_wait, ram_req, prg_done, prg_error,
               ram_addr, ram_dout, prg_start, prg_end}, 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            b = mk_img(vt[i].start, vt[i].nhdr, vt[i].npay, 1'b0);
            run_case(b, -1, vt[i].lat);
            check("tbl_nw", 64'(last_nw), 64'(vt[i].e_nw));
            check("tbl_err", 64'(prg_error), 64'(vt[i].e_err));
            if (vt[i].nhdr >= 2)
                check("tbl_end", 64'(prg_end), 64'(vt[i].e_end));
        end

        // header 00 C0 must touch no BASIC pointer
        b = mk_img(16'hC000, 2, 4, 1'b1);
        run_case(b, -1, 2);
        t = 0;
        for (int i = wq_base; i < wq.size(); i++)
            if (wq[i][23:8] >= 16'h002D && wq[i][23:8] <= 16'h0032)
                t++;
        check("no_basic_ptrs", 64'(t), 64'd0);

        // payload byte with wrong ioctl_addr flags an error but still lands
        b = mk_img(16'h3000, 2, 3, 1'b1);
        run_case(b, 3, 1);

        // ack withheld for 50 cycles mid-payload
        b = mk_img(16'h2000, 2, 6, 1'b1);
        ok_wait = 1'b1;
        fork
            run_case(b, -1, 3);
            begin
                t = 0;
                while (!(ram_req && wq.size() - wq_base >= 2) && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                hold_ack = 1'b1;
                repeat (50) begin
                    @(negedge clk);
                    if (ioctl_wait !== 1'b1)
                        ok_wait = 1'b0;
                end
                hold_ack = 1'b0;
            end
        join
        check("wait_held", 64'(ok_wait), 64'd1);

        // reset asserted while the pointer patch is in progress
        lat = 3;
        dl_begin();
        send_byte(23'd0, 8'h01);
        send_byte(23'd1, 8'h08);
        send_byte(23'd2, 8'h5A);
        send_byte(23'd3, 8'hA5);
        dl_end();
        t = 0;
        while (wq.size() - wq_base < 3 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("reached_ptr_wr", 64'(wq.size() - wq_base >= 3), 64'd1);
        #2 reset_n = 1'b0;
        #1 check("async_reset",
                 {ioctl_wait, ram_req, prg_done, prg_error,
                  ram_addr, ram_dout, prg_start, prg_end}, 64'd0);
        load_prg = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        nb = wq.size();
        t = done_cnt;
        repeat (20) @(negedge clk);
        check("no_writes_after_reset", 64'(wq.size() - nb), 64'd0);
        check("no_done_after_reset", 64'(done_cnt - t), 64'd0);
        b = mk_img(16'h0801, 2, 2, 1'b1);
        run_case(b, -1, 1);

        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 3))
                0: s = 16'h0801;
                1: s = 16'(16'hFFF0 + $urandom_range(0, 15));
                default: s = 16'($urandom);
            endcase
            np = $urandom_range(0, 10);
            bad = -1;
            if (np > 0 && $urandom_range(0, 5) == 0)
                bad = 2 + $urandom_range(0, np - 1);
            if ($urandom_range(0, 7) == 0)
                b = mk_img(s, $urandom_range(0, 1), 0, 1'b1);
            else
                b = mk_img(s, 2, np, 1'b1);
            run_case(b, bad, $urandom_range(0, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prg_ram_loader.md
Name: prg_ram_loader

Overview:
- Consumes the ioctl byte stream from the SD loader whenever load_prg is high.
- Strips the 2-byte little-endian PRG header and writes the payload into C64 main RAM through a req/ack write port.
- On completion, patches the KERNAL/BASIC end-of-program pointers so RUN/LIST work without a real LOAD.
- Sits between the SD loader and the C64 RAM arbiter; ioctl_wait is its back-pressure to the loader.

Parameters:
- PTR_UPDATE, 1, 1 = write zero-page pointers after payload; 0 = skip pointer phase.
- BASIC_START, 16'h0801, load address that also triggers BASIC pointer patching ($2D–$32).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download window active
- load_prg  in  1  current download is a PRG image
- ioctl_addr  in  23  byte offset in image (0 = header low byte)
- ioctl_data  in  8  image byte, valid with ioctl_wr
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_wait  out  1  back-pressure to loader
- ram_addr  out  16  C64 RAM write address
- ram_dout  out  8  C64 RAM write data
- ram_req  out  1  write request, held until ack
- ram_ack  in  1  one-cycle acceptance from arbiter
- prg_start  out  16  latched load address
- prg_end  out  16  first address after payload
- prg_done  out  1  one-cycle pulse when load and pointer patch finish
- prg_error  out  1  sticky until next download: header short or payload wrapped past $FFFF

Behaviour:
- Reset (async, reset_n low): state IDLE; ioctl_wait=0, ram_req=0, ram_addr=0, ram_dout=0, prg_start=0, prg_end=0, prg_done=0, prg_error=0.
- A strobe counts only when ioctl_wr && ioctl_download && load_prg. All other strobes are ignored.
- Upstream never strobes while ioctl_wait=1.
- Upstream leaves at least 1 idle cycle between strobes.
- States and transitions:
  - IDLE: on rising edge of ioctl_download && load_prg, clear prg_error, go to HDR_LO.
  - HDR_LO: on a strobe, prg_start[7:0] <= data; go to HDR_HI.
  - HDR_HI: on a strobe, prg_start[15:8] <= data; ptr <= {data, prg_start[7:0]}; go to DATA.
  - DATA: on a strobe with no wrap flag set:
    - ram_addr <= ptr, ram_dout <= data, ram_req <= 1, ioctl_wait <= 1 (registered, effective next cycle); go to RAM_WR.
    - If the wrap flag is set, drop the byte and set prg_error.
  - RAM_WR: hold ram_req/addr/dout until ram_ack.
    - On ack: ram_req <= 0, ioctl_wait <= 0, ptr <= ptr+1.
    - If ptr was 16'hFFFF, set the wrap flag instead of wrapping to 0.
    - Return to DATA.
  - DATA, when ioctl_download falls:
    - Fewer than 2 header bytes received: prg_error <= 1, go to DONE.
    - Otherwise prg_end <= ptr (17-bit internally, saturates to 16'hFFFF when wrapped).
    - Then go to PTR_WR if PTR_UPDATE, else DONE.
  - Falling ioctl_download in HDR_LO/HDR_HI: prg_error <= 1, go to DONE.
  - Falling ioctl_download in RAM_WR: finish the outstanding write first, then evaluate as in DATA.
  - PTR_WR: sequential writes, each using the same req/ack handshake:
    - $AE/$AF = prg_end low/high.
    - If prg_start == BASIC_START, also write $2D/$2E, $2F/$30, $31/$32 = prg_end low/high.
    - An index counter of 0..7 selects address and byte.
  - DONE: prg_done=1 for exactly one cycle; go to IDLE.
- ioctl_wait is held at 1 throughout PTR_WR and DONE.
- Header offsets are taken from the strobe count, not from ioctl_addr. ioctl_addr is used only for a consistency check: payload byte k arrives with ioctl_addr == k+2, otherwise prg_error.
- Worst case per byte: 1 accept cycle + ack latency; there is no buffering (depth 1).
- A new download rising edge while not in IDLE is ignored until IDLE.
- Reset mid-operation aborts immediately: ram_req drops and no pointers are written.

Decomposition:
- Shared package c64_loader_pkg holds:
  - state enum typedef;
  - zero-page pointer address constants ($2D,$2F,$31,$AE);
  - BASIC_START default.
- One sub-module, prg_ptr_writer: PTR_WR sequencer (index counter + address/byte mux + handshake), started with prg_end/is_basic and returning a done pulse.

Test Plan:
- Header 01 08, payload AA BB CC, ack latency 3 cycles:
  - RAM writes $0801=AA, $0802=BB, $0803=CC; prg_end=$0804.
  - Pointer writes $AE=04,$AF=08, then $2D..$32 = 04/08 pairs; one prg_done pulse.
- Header 00 C0, payload 4 bytes:
  - Writes $C000–$C003; only $AE/$AF written (=04/C0); no $2D–$32 writes.
- Header FE FF, payload 4 bytes:
  - Writes $FFFE,$FFFF only; prg_error=1; prg_end=$FFFF; no write to $0000.
- Download of 1 byte then ioctl_download falls:
  - No RAM writes; prg_error=1; prg_done pulses.
- ram_ack withheld for 50 cycles mid-payload:
  - ioctl_wait high the whole time; ram_addr/ram_dout stable; no lost or duplicated byte.
- reset_n low during PTR_WR:
  - All outputs go to reset values asynchronously; after release, a new download loads correctly.
